// File: rtl/mochila_mailbox.sv
// Memory-mapped RX/TX FIFO mailbox with an OBI slave port and stream sides.
// Optional RX threshold interrupt is built when MOCHILA_MAILBOX_IRQ_EN is defined.
package mochila_mailbox_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module mochila_mailbox
    import mochila_mailbox_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  obi_req_t    slave_req_i,
    output obi_resp_t   slave_resp_o,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    input  logic [31:0] rx_data_i,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] tx_data_o,
    output logic        irq_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL_CNT = 5'(DEPTH);

    logic [31:0]   rx_mem_q [DEPTH];
    logic [31:0]   tx_mem_q [DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [4:0]    rx_count_q, rx_count_d, tx_count_q, tx_count_d;
    logic          tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          gnt, wr, rd;
    logic          hit_tx, hit_rx, hit_status, hit_ctrl, hit_thresh;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_clr, tx_push, tx_pop, tx_clr;
    logic [31:0]   tx_wdata;
    logic          irq_en;
    logic [4:0]    thresh;
    logic          unused_bits;

    assign unused_bits = ^{slave_req_i.addr[31:5], slave_req_i.addr[1:0]};

    assign gnt = slave_req_i.req & ~rst_i;
    assign wr  = gnt & slave_req_i.we;
    assign rd  = gnt & ~slave_req_i.we;

    always_comb begin
        hit_tx     = 1'b0;
        hit_rx     = 1'b0;
        hit_status = 1'b0;
        hit_ctrl   = 1'b0;
        hit_thresh = 1'b0;
        case (slave_req_i.addr[4:2])
            3'd0:    hit_tx     = 1'b1;
            3'd1:    hit_rx     = 1'b1;
            3'd2:    hit_status = 1'b1;
            3'd3:    hit_ctrl   = 1'b1;
            3'd4:    hit_thresh = 1'b1;
            default: ;
        endcase
    end

    assign rx_full  = (rx_count_q == FULL_CNT);
    assign rx_empty = (rx_count_q == 5'd0);
    assign tx_full  = (tx_count_q == FULL_CNT);
    assign tx_empty = (tx_count_q == 5'd0);

    assign rx_ready_o = ~rx_full & ~rst_i;
    assign tx_valid_o = ~tx_empty & ~rst_i;
    assign tx_data_o  = tx_mem_q[tx_rptr_q];

    assign rx_push = rx_valid_i & rx_ready_o;
    assign rx_pop  = rd & hit_rx & ~rx_empty;
    assign rx_clr  = wr & hit_ctrl & slave_req_i.be[0] & slave_req_i.wdata[1];
    assign tx_push = wr & hit_tx & ~tx_full;
    assign tx_pop  = tx_valid_o & tx_ready_i;
    assign tx_clr  = wr & hit_ctrl & slave_req_i.be[0] & slave_req_i.wdata[0];

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            tx_wdata[b*8 +: 8] = slave_req_i.be[b] ? slave_req_i.wdata[b*8 +: 8] : 8'h00;
        end
    end

    // A flush overrides any push/pop landing in the same cycle.
    always_comb begin
        rx_wptr_d  = rx_wptr_q + AW'(rx_push);
        rx_rptr_d  = rx_rptr_q + AW'(rx_pop);
        rx_count_d = rx_count_q + {4'd0, rx_push} - {4'd0, rx_pop};
        if (rx_clr) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_count_d = '0;
        end
        tx_wptr_d  = tx_wptr_q + AW'(tx_push);
        tx_rptr_d  = tx_rptr_q + AW'(tx_pop);
        tx_count_d = tx_count_q + {4'd0, tx_push} - {4'd0, tx_pop};
        if (tx_clr) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_count_d = '0;
        end
    end

    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_udf_d = rx_udf_q;
        if (wr & hit_tx & tx_full)
            tx_ovf_d = 1'b1;
        if (rd & hit_rx & rx_empty)
            rx_udf_d = 1'b1;
        if (wr & hit_status & slave_req_i.be[3]) begin
            if (slave_req_i.wdata[24])
                tx_ovf_d = 1'b0;
            if (slave_req_i.wdata[25])
                rx_udf_d = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = gnt;
        rdata_d  = '0;
        if (rd) begin
            case (1'b1)
                hit_rx:     rdata_d = rx_empty ? 32'd0 : rx_mem_q[rx_rptr_q];
                hit_status: rdata_d = {6'd0, rx_udf_q, tx_ovf_q, 6'd0, rx_empty,
                                       tx_full, 3'd0, rx_count_q, 3'd0, tx_count_q};
                hit_ctrl:   rdata_d = {29'd0, irq_en, 2'b00};
                hit_thresh: rdata_d = {27'd0, thresh};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_udf_q   <= rx_udf_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push)
            rx_mem_q[rx_wptr_q] <= rx_data_i;
        if (tx_push)
            tx_mem_q[tx_wptr_q] <= tx_wdata;
    end

`ifdef MOCHILA_MAILBOX_IRQ_EN
    logic       irq_en_q, irq_en_d;
    logic [4:0] thresh_q, thresh_d;
    logic       irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (wr & slave_req_i.be[0]) begin
            if (hit_ctrl)
                irq_en_d = slave_req_i.wdata[2];
            if (hit_thresh)
                thresh_d = slave_req_i.wdata[4:0];
        end
        irq_d = irq_en_q & (thresh_q != 5'd0) & (rx_count_q >= thresh_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_q <= 1'b0;
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en = irq_en_q;
    assign thresh = thresh_q;
    assign irq_o  = irq_q & ~rst_i;
`else
    assign irq_en = 1'b0;
    assign thresh = 5'd0;
    assign irq_o  = 1'b0;
`endif

    // Outputs are forced quiet during reset, hiding any in-flight response.
    assign slave_resp_o.gnt    = gnt;
    assign slave_resp_o.rvalid = rvalid_q & ~rst_i;
    assign slave_resp_o.rdata  = rst_i ? 32'd0 : rdata_q;

endmodule

// File: tb/tb_mochila_mailbox.sv
// Directed self-checking bench for mochila_mailbox (DEPTH = 8).
// Compile with MOCHILA_MAILBOX_IRQ_EN to exercise the interrupt path.
module tb_mochila_mailbox;
    import mochila_mailbox_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    obi_req_t    req;
    obi_resp_t   resp;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] rx_data = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    mochila_mailbox #(.DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .slave_req_i(req), .slave_resp_o(resp),
        .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic we, input logic [3:0] be, input logic [7:0] a,
                       input logic [31:0] wd, output logic [31:0] data);
        @(negedge clk);
        req = '{req: 1'b1, we: we, be: be, addr: {24'd0, a}, wdata: wd};
        #1 chk("gnt", 32'(resp.gnt), 32'd1);
        @(negedge clk);
        req.req = 1'b0;
        #1 chk("rvalid", 32'(resp.rvalid), 32'd1);
        data = resp.rdata;
    endtask

    task automatic push(input logic [31:0] d);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        req = '0;
        @(negedge clk);
        req.req = 1'b1;
        #1;
        chk("rst_gnt", 32'(resp.gnt), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("rst_rvalid", 32'(resp.rvalid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        req.req = 1'b0;
        rst = 1'b0;
        #1 chk("post_rst_rx_ready", 32'(rx_ready), 32'd1);
        acc(0, 4'hF, 8'h08, 0, rd); chk("status_init", rd, 32'h0002_0000);

        // back-to-back STATUS then CTRL reads
        @(negedge clk);
        req = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h08, wdata: 32'd0};
        @(negedge clk);
        req.addr = 32'h0C;
        #1 chk("b2b_rv1", 32'(resp.rvalid), 32'd1);
        chk("b2b_rd1", resp.rdata, 32'h0002_0000);
        @(negedge clk);
        req.req = 1'b0;
        #1 chk("b2b_rv2", 32'(resp.rvalid), 32'd1);
        chk("b2b_rd2", resp.rdata, 32'd0);

        // RX fill and drain
        for (int i = 1; i <= 8; i++) push(32'hA5A5_0000 + 32'(i));
        #1 chk("rx_full_ready", 32'(rx_ready), 32'd0);
        acc(0, 4'hF, 8'h08, 0, rd); chk("status_rx8", rd, 32'h0000_0800);
        for (int i = 1; i <= 8; i++) begin
            acc(0, 4'hF, 8'h04, 0, rd);
            chk("rx_order", rd, 32'hA5A5_0000 + 32'(i));
        end
        acc(0, 4'hF, 8'h08, 0, rd); chk("status_rx_empty", rd, 32'h0002_0000);

        // underflow and byte-enable masking
        acc(0, 4'hF, 8'h04, 0, rd); chk("udf_rdata", rd, 32'd0);
        acc(0, 4'hF, 8'h08, 0, rd); chk("status_udf", rd, 32'h0202_0000);
        acc(1, 4'h8, 8'h08, 32'h0200_0000, rd);
        acc(0, 4'hF, 8'h08, 0, rd); chk("udf_clr", rd, 32'h0002_0000);
        acc(1, 4'b0011, 8'h00, 32'hDEAD_BEEF, rd);
        #1 chk("be_tx_valid", 32'(tx_valid), 32'd1);
        chk("be_tx_data", tx_data, 32'h0000_BEEF);
        @(negedge clk); tx_ready = 1'b1;
        @(negedge clk); tx_ready = 1'b0;
        #1 chk("be_tx_drained", 32'(tx_valid), 32'd0);

        // TX overflow and drain
        for (int i = 0; i < 9; i++) acc(1, 4'hF, 8'h00, 32'h100 + 32'(i), rd);
        acc(0, 4'hF, 8'h08, 0, rd); chk("status_tx_ovf", rd, 32'h0103_0008);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tx_ready = 1'b1;
            #1 chk("tx_pop_valid", 32'(tx_valid), 32'd1);
            chk("tx_pop_data", tx_data, 32'h100 + 32'(i));
        end
        @(negedge clk); tx_ready = 1'b0;
        #1 chk("tx_empty", 32'(tx_valid), 32'd0);
        acc(1, 4'hF, 8'h08, 32'h0100_0000, rd);
        acc(0, 4'hF, 8'h08, 0, rd); chk("ovf_clr", rd, 32'h0002_0000);

        // RX full: pop wins, push refused; then push+pop at count 7
        for (int i = 0; i < 8; i++) push(32'h200 + 32'(i));
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 32'hBAD;
        req = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h04, wdata: 32'd0};
        #1 chk("full_push_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0; req.req = 1'b0;
        #1 chk("full_pop_data", resp.rdata, 32'h200);
        acc(0, 4'hF, 8'h08, 0, rd); chk("status_rx7", rd, 32'h0000_0700);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 32'h2FF;
        req = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h04, wdata: 32'd0};
        #1 chk("pp_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0; req.req = 1'b0;
        #1 chk("pp_data", resp.rdata, 32'h201);
        acc(0, 4'hF, 8'h08, 0, rd); chk("pp_count", rd, 32'h0000_0700);
        for (int i = 0; i < 7; i++) begin
            acc(0, 4'hF, 8'h04, 0, rd);
            chk("rx_drain", rd, (i < 6) ? 32'h202 + 32'(i) : 32'h2FF);
        end

        // flush with coincident push; TX flush
        push(32'h31); push(32'h32);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 32'h77;
        req = '{req: 1'b1, we: 1'b1, be: 4'h1, addr: 32'h0C, wdata: 32'h2};
        #1 chk("flush_push_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0; req.req = 1'b0;
        acc(0, 4'hF, 8'h08, 0, rd); chk("rx_flush", rd, 32'h0002_0000);
        acc(1, 4'hF, 8'h00, 32'h41, rd);
        acc(1, 4'hF, 8'h00, 32'h42, rd);
        acc(1, 4'h1, 8'h0C, 32'h1, rd);
        #1 chk("tx_flush", 32'(tx_valid), 32'd0);
        acc(0, 4'hF, 8'h0C, 0, rd); chk("ctrl_selfclr", rd, 32'd0);

        acc(1, 4'h1, 8'h10, 32'd3, rd);
        acc(1, 4'h1, 8'h0C, 32'h4, rd);
`ifdef MOCHILA_MAILBOX_IRQ_EN
        acc(0, 4'hF, 8'h10, 0, rd); chk("thresh_rd", rd, 32'd3);
        acc(0, 4'hF, 8'h0C, 0, rd); chk("ctrl_rd", rd, 32'h4);
        push(32'h51); push(32'h52); push(32'h53);
        #1 chk("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        #1 chk("irq_set", 32'(irq), 32'd1);
        acc(0, 4'hF, 8'h04, 0, rd); chk("irq_pop", rd, 32'h51);
        @(negedge clk);
        #1 chk("irq_clr", 32'(irq), 32'd0);
        push(32'h54); push(32'h55);
`else
        acc(0, 4'hF, 8'h10, 0, rd); chk("thresh_rd", rd, 32'd0);
        acc(0, 4'hF, 8'h0C, 0, rd); chk("ctrl_rd", rd, 32'd0);
        push(32'h51); push(32'h52); push(32'h53);
        @(negedge clk); @(negedge clk);
        #1 chk("irq_tied", 32'(irq), 32'd0);
        push(32'h54);
`endif

        // reset with 4 RX entries and a read in flight
        @(negedge clk);
        req = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h04, wdata: 32'd0};
        @(negedge clk);
        rst = 1'b1;
        req.addr = 32'h08;
        #1 chk("rst_mid_rvalid", 32'(resp.rvalid), 32'd0);
        chk("rst_mid_rdata", resp.rdata, 32'd0);
        chk("rst_mid_gnt", 32'(resp.gnt), 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0; req.req = 1'b0;
        #1 chk("rel_rx_ready", 32'(rx_ready), 32'd1);
        chk("rel_tx_valid", 32'(tx_valid), 32'd0);
        chk("rel_irq", 32'(irq), 32'd0);
        acc(0, 4'hF, 8'h08, 0, rd); chk("rel_status", rd, 32'h0002_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
